eff_addr_unit: RTL

EFF_ADDR_UNIT -- requirements
Module: eff_addr_unit

---
 rtl/eau_pkg.sv | 25 ++
 rtl/tap_delay_line.sv | 24 ++
 rtl/eff_addr_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/eau_pkg.sv
// Shared encodings for the effective-address unit: addressing modes, FSM states
// and AUTOINC step sizes.
package eau_pkg;

  typedef enum logic [2:0] {
    MODE_NOP      = 3'd0,
    MODE_AUTOINC  = 3'd1,
    MODE_IDX_SRC  = 3'd2,
    MODE_IDX_DST  = 3'd3,
    MODE_SYMBOLIC = 3'd4,
    MODE_ABSOLUTE = 3'd5,
    MODE_RSV6     = 3'd6,
    MODE_RSV7     = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MDB = 1'b1
  } state_e;

  localparam int STEP_BYTE    = 1;
  localparam int STEP_WORD    = 2;
  localparam int STEP_DEFAULT = 1;

endpackage

// File: rtl/tap_delay_line.sv
// Register history: taps[k] holds din as sampled k+1 clocks ago.
// Shifts on every clock, independent of any FSM state.
module tap_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             din,
  output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/eff_addr_unit.sv
// Effective-address unit: computes an address from register history, PC and a
// memory offset word. Define EAU_BYTE_INC_EN to make the AUTOINC step follow bw.
module eff_addr_unit
  import eau_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 3,
  parameter int TIMEOUT = 15,
  localparam int TAP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [TAP_W-1:0] tap_sel,
  input  logic             bw,
  input  logic [WIDTH-1:0] src_in,
  input  logic [WIDTH-1:0] dst_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] mdb_in,
  input  logic             mdb_valid,
  output logic             busy,
  output logic [WIDTH-1:0] ea_out,
  output logic             ea_valid,
  output logic             err
);

  logic [DEPTH-1:0][WIDTH-1:0] src_taps;
  logic [DEPTH-1:0][WIDTH-1:0] dst_taps;

  tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_src_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (src_in),
    .taps  (src_taps)
  );

  tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dst_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dst_in),
    .taps  (dst_taps)
  );

  logic [WIDTH-1:0] step;
`ifdef EAU_BYTE_INC_EN
  assign step = bw ? WIDTH'(STEP_BYTE) : WIDTH'(STEP_WORD);
`else
  logic unused_bw;
  assign unused_bw = bw;
  assign step      = WIDTH'(STEP_DEFAULT);
`endif

  state_e           state, state_next;
  logic [WIDTH-1:0] base, base_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] ea_next;
  logic             ea_valid_next, err_next;
  logic             tap_bad;
  logic [WIDTH-1:0] src_tap, dst_tap;

  assign tap_bad = int'(tap_sel) >= DEPTH;
  assign src_tap = tap_bad ? '0 : src_taps[tap_sel];
  assign dst_tap = tap_bad ? '0 : dst_taps[tap_sel];
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      base     <= '0;
      cnt      <= '0;
      ea_out   <= '0;
      ea_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      base     <= base_next;
      cnt      <= cnt_next;
      ea_out   <= ea_next;
      ea_valid <= ea_valid_next;
      err      <= err_next;
    end
  end

  // ABSOLUTE uses a zero base so every memory-operand mode shares base + mdb.
  always_comb begin
    state_next    = state;
    base_next     = base;
    cnt_next      = cnt;
    ea_next       = ea_out;
    ea_valid_next = 1'b0;
    err_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (tap_bad) begin
            err_next = 1'b1;
          end else begin
            case (mode_e'(mode))
              MODE_NOP: begin
                ea_next       = '0;
                ea_valid_next = 1'b1;
              end
              MODE_AUTOINC: begin
                ea_next       = src_tap + step;
                ea_valid_next = 1'b1;
              end
              MODE_IDX_SRC: begin
                base_next  = src_tap;
                cnt_next   = '0;
                state_next = ST_WAIT_MDB;
              end
              MODE_IDX_DST: begin
                base_next  = dst_tap;
                cnt_next   = '0;
                state_next = ST_WAIT_MDB;
              end
              MODE_SYMBOLIC: begin
                base_next  = pc_in;
                cnt_next   = '0;
                state_next = ST_WAIT_MDB;
              end
              MODE_ABSOLUTE: begin
                base_next  = '0;
                cnt_next   = '0;
                state_next = ST_WAIT_MDB;
              end
              default: begin
                err_next = 1'b1;
              end
            endcase
          end
        end
      end
      ST_WAIT_MDB: begin
        if (mdb_valid) begin
          ea_next       = base + mdb_in;
          ea_valid_next = 1'b1;
          state_next    = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
